// File: rtl/synth_pkg.sv
// Shared synthesiser widths and codes used by the voice mixer.
package synth_pkg;

    localparam int PHASE_W  = 10;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 18;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_e;

    localparam logic [1:0] PIPE_STATE_UPDATE = 2'd2;

endpackage

// File: rtl/voice_mixer_sine_rom.sv
// sine_rom: combinational quarter-wave table, round(511*sin(pi/2*k/256)) for k = 0..255.
module sine_rom (
    input  logic [7:0] addr,
    output logic [8:0] mag
);

    // Table contents are evaluated at elaboration with a fixed-point (Q30) Taylor series.
    function automatic int sine_q(input int k);
        longint x;
        longint term;
        longint sum;
        x    = (64'sd1686629713 * longint'(k)) / 64'sd256;
        sum  = x;
        term = x;
        for (int n = 1; n <= 7; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return int'((sum * 64'sd511 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    logic [8:0] table_w [256];

    for (genvar k = 0; k < 256; k++) begin : g_rom
        assign table_w[k] = 9'(sine_q(k));
    end

    assign mag = table_w[addr];

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: per-voice waveform, gate and sweep accumulation into one saturated sample.
// Build option: define SINE_LUT_EN to include the sine table (otherwise sine voices are silent).
module voice_mixer
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 128,
    parameter int OUT_SHIFT  = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [1:0]                 i_pipeline_state,
    input  logic [PHASE_W-1:0]         i_phase,
    input  logic [7:0]                 i_voice_index,
    input  logic [1:0]                 i_waveform,
    input  logic                       i_SPI_flag,
    input  logic [7:0]                 i_SPI_voice_index,
    input  logic                       i_SPI_gate,
    output logic signed [SAMPLE_W-1:0] o_sample,
    output logic                       o_sample_valid
);

    localparam logic [8:0] VOICE_LIMIT = 9'(NUM_VOICES);
    localparam logic [8:0] LAST_VOICE  = 9'(NUM_VOICES - 1);

    function automatic logic signed [PHASE_W-1:0] wave_value(
        input logic [1:0]                wave,
        input logic [PHASE_W-1:0]        p,
        input logic signed [PHASE_W-1:0] sine_w
    );
        logic signed [PHASE_W:0] twice;
        logic signed [PHASE_W:0] tri_w;
        twice = $signed({1'b0, p[8:0], 1'b0});
        tri_w = p[9] ? (11'sd511 - twice) : (twice - 11'sd512);
        case (wave)
            WAVE_SAW:    wave_value = $signed({~p[9], p[8:0]});
            WAVE_SQUARE: wave_value = p[9] ? -10'sd511 : 10'sd511;
            WAVE_TRI:    wave_value = tri_w[PHASE_W-1:0];
            default:     wave_value = sine_w;
        endcase
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] s);
        if (s > 18'sd32767)
            sat16 = 16'sh7fff;
        else if (s < -18'sd32768)
            sat16 = 16'sh8000;
        else
            sat16 = s[SAMPLE_W-1:0];
    endfunction

    logic                        gate [256];
    logic                        vld_p1;
    logic [PHASE_W-1:0]          phase_p1;
    logic [7:0]                  voice_p1;
    logic                        gate_p1;
    logic [1:0]                  wave_q;
    logic                        vld_p2;
    logic signed [PHASE_W-1:0]   w_p2;
    logic [7:0]                  voice_p2;
    logic signed [ACC_W-1:0]     acc;
    logic                        sync;
    logic signed [PHASE_W-1:0]   sine_w;
    logic signed [ACC_W-1:0]     sum_s;
    logic signed [ACC_W-1:0]     shifted;
    logic                        is_last;
    logic                        sync_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 256; i++) gate[i] <= 1'b0;
        end else if (i_SPI_flag && ({1'b0, i_SPI_voice_index} < VOICE_LIMIT)) begin
            gate[i_SPI_voice_index] <= i_SPI_gate;
        end
    end

    // ---- S1: capture phase, voice and gate (gate read before any same-cycle write)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1 <= 1'b0;
            wave_q <= WAVE_SAW;
        end else begin
            vld_p1 <= (i_pipeline_state == PIPE_STATE_UPDATE);
            if ((i_pipeline_state == PIPE_STATE_UPDATE) && (i_voice_index == 8'd0))
                wave_q <= i_waveform;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_pipeline_state == PIPE_STATE_UPDATE) begin
            phase_p1 <= i_phase;
            voice_p1 <= i_voice_index;
            gate_p1  <= gate[i_voice_index];
        end
    end

`ifdef SINE_LUT_EN
    logic [7:0] rom_addr;
    logic [8:0] sine_mag;

    assign rom_addr = phase_p1[8] ? ~phase_p1[7:0] : phase_p1[7:0];

    sine_rom u_sine_rom (
        .addr (rom_addr),
        .mag  (sine_mag)
    );

    assign sine_w = phase_p1[9] ? -$signed({1'b0, sine_mag}) : $signed({1'b0, sine_mag});
`else
    assign sine_w = '0;
`endif

    // ---- S2: waveform value, muted by gate or out-of-range voice
    always_ff @(posedge i_clk) begin
        if (i_reset)
            vld_p2 <= 1'b0;
        else
            vld_p2 <= vld_p1;
    end

    always_ff @(posedge i_clk) begin
        voice_p2 <= voice_p1;
        if (gate_p1 && ({1'b0, voice_p1} < VOICE_LIMIT))
            w_p2 <= wave_value(wave_q, phase_p1, sine_w);
        else
            w_p2 <= '0;
    end

    assign sum_s     = acc + {{(ACC_W-PHASE_W){w_p2[PHASE_W-1]}}, w_p2};
    assign shifted   = sum_s >>> OUT_SHIFT;
    assign is_last   = ({1'b0, voice_p2} == LAST_VOICE);
    assign sync_next = sync | (voice_p2 == 8'd0);

    // ---- S3: accumulate; emit at the last voice once a full sweep has been seen
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc            <= '0;
            sync           <= 1'b0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            if (vld_p2) begin
                sync <= sync_next;
                if (is_last) begin
                    acc <= '0;
                    if (sync_next) begin
                        o_sample       <= sat16(shifted);
                        o_sample_valid <= 1'b1;
                    end
                end else begin
                    acc <= sum_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: three instances (4 voices unshifted, 4 voices shift 2, 256 voices).
module tb_voice_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pstate;
    logic [9:0]  phase;
    logic [7:0]  vidx;
    logic [1:0]  wave;
    logic        spi_flag;
    logic [7:0]  spi_idx;
    logic        spi_gate;

    logic [15:0] s4, s4sh, s256;
    logic        v4, v4sh, v256;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_VOICES(4), .OUT_SHIFT(0)) dut (
        .i_clk(clk), .i_reset(rst), .i_pipeline_state(pstate), .i_phase(phase),
        .i_voice_index(vidx), .i_waveform(wave), .i_SPI_flag(spi_flag),
        .i_SPI_voice_index(spi_idx), .i_SPI_gate(spi_gate),
        .o_sample(s4), .o_sample_valid(v4)
    );

    voice_mixer #(.NUM_VOICES(4)) dut_sh (
        .i_clk(clk), .i_reset(rst), .i_pipeline_state(pstate), .i_phase(phase),
        .i_voice_index(vidx), .i_waveform(wave), .i_SPI_flag(spi_flag),
        .i_SPI_voice_index(spi_idx), .i_SPI_gate(spi_gate),
        .o_sample(s4sh), .o_sample_valid(v4sh)
    );

    voice_mixer #(.NUM_VOICES(256), .OUT_SHIFT(0)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_pipeline_state(pstate), .i_phase(phase),
        .i_voice_index(vidx), .i_waveform(wave), .i_SPI_flag(spi_flag),
        .i_SPI_voice_index(spi_idx), .i_SPI_gate(spi_gate),
        .o_sample(s256), .o_sample_valid(v256)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi(input logic [7:0] idx, input logic g);
        spi_flag = 1'b1;
        spi_idx  = idx;
        spi_gate = g;
        tick();
        spi_flag = 1'b0;
    endtask

    // One voice slot: state 2 (capture), then 0 and 1; returns #1 after the voice's S3 edge.
    task automatic voice(input logic [7:0] idx, input logic [9:0] ph, input logic r);
        pstate = 2'd2;
        vidx   = idx;
        phase  = ph;
        rst    = r;
        tick();
        rst    = 1'b0;
        pstate = 2'd0;
        tick();
        pstate = 2'd1;
        tick();
    endtask

    task automatic sweep4(input logic [9:0] p0, input logic [9:0] p1,
                          input logic [9:0] p2, input logic [9:0] p3);
        voice(8'd0, p0, 1'b0);
        check("valid_after_v0", 16'(v4), 16'd0);
        voice(8'd1, p1, 1'b0);
        voice(8'd2, p2, 1'b0);
        check("valid_after_v2", 16'(v4), 16'd0);
        voice(8'd3, p3, 1'b0);
    endtask

    initial begin
        rst = 1'b1; pstate = 2'd0; phase = '0; vidx = '0; wave = 2'd0;
        spi_flag = 1'b0; spi_idx = '0; spi_gate = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_sample", s4, 16'd0);
        check("reset_valid", 16'(v4), 16'd0);
        check("reset_sample_256", s256, 16'd0);
        check("reset_valid_256", 16'(v256), 16'd0);

        for (int i = 0; i < 4; i++) spi(8'(i), 1'b1);

        // Saw, phase 0x300 on all voices: 4 x 256
        wave = 2'd0;
        sweep4(10'h300, 10'h300, 10'h300, 10'h300);
        check("saw_valid", 16'(v4), 16'd1);
        check("saw_sample", s4, 16'd1024);
        check("saw_shift2", s4sh, 16'd256);
        tick();
        check("saw_valid_drop", 16'(v4), 16'd0);
        check("saw_hold", s4, 16'd1024);
        sweep4(10'h300, 10'h300, 10'h300, 10'h300);
        check("saw_valid_2nd", 16'(v4), 16'd1);
        check("saw_sample_2nd", s4, 16'd1024);

        // Square with voice 2 muted; mid-sweep waveform change is deferred
        wave = 2'd1;
        spi(8'd2, 1'b0);
        spi(8'd9, 1'b1);
        voice(8'd0, 10'h100, 1'b0);
        voice(8'd1, 10'h100, 1'b0);
        wave = 2'd0;
        voice(8'd2, 10'h100, 1'b0);
        voice(8'd3, 10'h100, 1'b0);
        check("square_valid", 16'(v4), 16'd1);
        check("square_muted", s4, 16'd1533);
        sweep4(10'h100, 10'h100, 10'h100, 10'h100);
        check("wave_change_next", s4, -16'sd768);
        spi(8'd2, 1'b1);

        // Triangle: -512 + 0 + 511 - 511
        wave = 2'd2;
        sweep4(10'h000, 10'h100, 10'h200, 10'h3ff);
        check("tri_sample", s4, -16'sd512);
        check("tri_shift2", s4sh, -16'sd128);

        // Sine
        wave = 2'd3;
        sweep4(10'h100, 10'h300, 10'h000, 10'h000);
        check("sine_cancel", s4, 16'd0);
        sweep4(10'h100, 10'h000, 10'h000, 10'h000);
`ifdef SINE_LUT_EN
        check("sine_peak", s4, 16'd511);
`else
        check("sine_off", s4, 16'd0);
`endif
        sweep4(10'h080, 10'h100, 10'h000, 10'h000);
`ifdef SINE_LUT_EN
        check("sine_eighth", s4, 16'd872);
`else
        check("sine_off_2", s4, 16'd0);
`endif

        // Reset during voice 2: partial sweep must not be emitted
        wave = 2'd0;
        voice(8'd0, 10'h300, 1'b0);
        voice(8'd1, 10'h300, 1'b0);
        voice(8'd2, 10'h300, 1'b1);
        voice(8'd3, 10'h300, 1'b0);
        check("reset_partial_valid", 16'(v4), 16'd0);
        check("reset_partial_sample", s4, 16'd0);
        sweep4(10'h300, 10'h300, 10'h300, 10'h300);
        check("gates_cleared_valid", 16'(v4), 16'd1);
        check("gates_cleared_sample", s4, 16'd0);
        for (int i = 0; i < 4; i++) spi(8'(i), 1'b1);
        sweep4(10'h300, 10'h300, 10'h300, 10'h300);
        check("after_reset_sample", s4, 16'd1024);

        // Saturation on the 256-voice instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wave = 2'd1;
        for (int i = 0; i < 256; i++) spi(8'(i), 1'b1);
        for (int i = 0; i < 256; i++) voice(8'(i), 10'h100, 1'b0);
        check("sat_pos_valid", 16'(v256), 16'd1);
        check("sat_pos", s256, 16'h7fff);
        for (int i = 0; i < 255; i++) voice(8'(i), 10'h200, 1'b0);
        check("sat_mid_valid", 16'(v256), 16'd0);
        voice(8'd255, 10'h200, 1'b0);
        check("sat_neg_valid", 16'(v256), 16'd1);
        check("sat_neg", s256, 16'h8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
